// File: rtl/ps2_host_tx_if.sv
// Command handshake and transfer status between a requester and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, ack_err, timeout
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, ack_err, timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
// Pads are driven open-drain through the *_oe outputs (1 = pull low).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6600,
  parameter int RTS_CYCLES     = 16,
  parameter int START_TIMEOUT  = 975000,
  parameter int PACKET_TIMEOUT = 130000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

  localparam int T1 = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
  localparam int T2 = (T1 > INHIBIT_CYCLES) ? T1 : INHIBIT_CYCLES;
  localparam int T3 = (T2 > RTS_CYCLES) ? T2 : RTS_CYCLES;
  localparam int TW = $clog2(T3 + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SHIFT, ACK_WAIT, RELEASE, DONE} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [8:0]      shift;
  logic [3:0]      cnt;
  logic            first_seen;
  logic            err;

  logic [1:0]      clk_sync;
  logic [1:0]      data_sync;
  logic [FW-1:0]   filt_cnt;
  logic            filt;
  logic            filt_q;
  logic            data_s;
  logic            fall;
  logic            in_link;
  logic            expired;
  logic [TW-1:0]   link_timer;

  // The device clock only changes level after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      filt_q    <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      filt_q    <= filt;
      if (clk_sync[1] == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign data_s     = data_sync[1];
  assign fall       = filt_q & ~filt;
  assign in_link    = (state == SHIFT) || (state == ACK_WAIT) || (state == RELEASE);
  assign expired    = in_link && (first_seen ? (timer == TW'(PACKET_TIMEOUT - 1))
                                             : (timer == TW'(START_TIMEOUT - 1)));
  assign link_timer = (fall && !first_seen) ? '0 : timer + TW'(1);

  // The timer restarts on the first device edge so the packet limit counts from there.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      timer        <= '0;
      shift        <= '0;
      cnt          <= '0;
      first_seen   <= 1'b0;
      err          <= 1'b0;
      ps2_clk_oe   <= 1'b0;
      ps2_data_oe  <= 1'b0;
      bus.tx_ready <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.ack_err  <= 1'b0;
      bus.timeout  <= 1'b0;
    end else if (expired) begin
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      bus.done    <= 1'b1;
      bus.timeout <= 1'b1;
      bus.ack_err <= 1'b0;
      state       <= DONE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.tx_valid) begin
            shift        <= {~^bus.tx_data, bus.tx_data};
            timer        <= '0;
            err          <= 1'b0;
            ps2_clk_oe   <= 1'b1;
            bus.busy     <= 1'b1;
            bus.tx_ready <= 1'b0;
            state        <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (timer == TW'(INHIBIT_CYCLES - 1)) begin
            timer       <= '0;
            ps2_data_oe <= 1'b1;
            state       <= RTS;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RTS: begin
          if (timer == TW'(RTS_CYCLES - 1)) begin
            timer      <= '0;
            cnt        <= '0;
            first_seen <= 1'b0;
            ps2_clk_oe <= 1'b0;
            state      <= SHIFT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        SHIFT: begin
          timer <= link_timer;
          if (fall) begin
            first_seen  <= 1'b1;
            ps2_data_oe <= ~shift[0];
            shift       <= {1'b1, shift[8:1]};
            if (cnt == 4'd9) begin
              state <= ACK_WAIT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        ACK_WAIT: begin
          timer <= link_timer;
          if (fall) begin
            err   <= data_s;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          timer <= link_timer;
          if (filt && data_s) begin
            bus.done    <= 1'b1;
            bus.ack_err <= err;
            bus.timeout <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          bus.done     <= 1'b0;
          bus.ack_err  <= 1'b0;
          bus.timeout  <= 1'b0;
          bus.busy     <= 1'b0;
          bus.tx_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// over wired-AND pads; timing constants are shrunk so every scenario runs quickly.
module tb_ps2_host_tx;

  localparam int INH      = 60;
  localparam int RTSC     = 16;
  localparam int START_TO = 2000;
  localparam int PACK_TO  = 3000;
  localparam int FILT     = 8;
  localparam int HALF     = 40;

  logic clk;
  logic rst;
  logic dev_clk;
  logic dev_data;
  logic ps2_clk_oe;
  logic ps2_data_oe;
  logic ps2_clk_pad;
  logic ps2_data_pad;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_CYCLES(RTSC),
    .START_TIMEOUT(START_TO),
    .PACKET_TIMEOUT(PACK_TO),
    .FILTER_LEN(FILT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ps2_clk_in(ps2_clk_pad),
    .ps2_data_in(ps2_data_pad),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  assign ps2_clk_pad  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_pad = dev_data & ~ps2_data_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation still running after 60000 cycles, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b, input bit hold);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  // Device side: waits for request-to-send, then generates 11 clock pulses, sampling on rises.
  task automatic run_device(input bit nack, input int stop_after, input int glitch_at,
                            output logic [9:0] rx);
    int t;
    rx = 'x;
    t = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (!(ps2_data_oe && !ps2_clk_oe)) return;
    repeat (100) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == stop_after) return;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) rx[k-1] = ps2_data_pad;
      if (k == 10 && !nack) dev_data = 1'b0;
      if (k == 11) begin
        dev_data = 1'b1;
        return;
      end
      if (k == glitch_at) begin
        repeat (15) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 18) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
  endtask

  task automatic wait_done(output bit seen, output logic ae, output logic to);
    seen = 1'b0;
    ae   = 1'bx;
    to   = 1'bx;
    for (int t = 0; t < 200 && !seen; t++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        ae   = bus.ack_err;
        to   = bus.timeout;
      end
    end
  endtask

  task automatic measure_request(output int n_inh, output int n_rts);
    n_inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && n_inh < 1000) begin
      n_inh++;
      @(negedge clk);
    end
    n_rts = 0;
    while (ps2_clk_oe && ps2_data_oe && n_rts < 1000) begin
      n_rts++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_clk_oe: got %b expected 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_oe: got %b expected 0", ps2_data_oe); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.ack_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack_err: got %b expected 0", bus.ack_err); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b expected 0", bus.timeout); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_ready: got %b expected 1", bus.tx_ready); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_send_ack();
    int n_inh, n_rts;
    logic [9:0] rx;
    bit seen;
    logic ae, to;
    send_byte(8'hF4, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL ack_busy: got %b expected 1", bus.busy); end
    measure_request(n_inh, n_rts);
    checks++; if (n_inh != INH) begin errors++; $display("[TB] FAIL ack_inhibit_len: got %0d expected %0d", n_inh, INH); end
    checks++; if (n_rts != RTSC) begin errors++; $display("[TB] FAIL ack_rts_len: got %0d expected %0d", n_rts, RTSC); end
    run_device(1'b0, 0, 0, rx);
    checks++; if (rx !== 10'h2F4) begin errors++; $display("[TB] FAIL ack_frame: got %h expected 2f4", rx); end
    wait_done(seen, ae, to);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL ack_done: got %b expected 1", seen); end
    checks++; if (ae !== 1'b0) begin errors++; $display("[TB] FAIL ack_ack_err: got %b expected 0", ae); end
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL ack_timeout: got %b expected 0", to); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nack();
    logic [9:0] rx;
    bit seen;
    logic ae, to;
    send_byte(8'hFF, 1'b0);
    run_device(1'b1, 0, 0, rx);
    checks++; if (rx !== 10'h3FF) begin errors++; $display("[TB] FAIL nack_frame: got %h expected 3ff", rx); end
    wait_done(seen, ae, to);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL nack_done: got %b expected 1", seen); end
    checks++; if (ae !== 1'b1) begin errors++; $display("[TB] FAIL nack_ack_err: got %b expected 1", ae); end
    checks++; if (to !== 1'b0) begin errors++; $display("[TB] FAIL nack_timeout: got %b expected 0", to); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_start_timeout();
    int t, t_rel, t_done;
    bit seen;
    logic ae, to, coe, doe;
    seen = 1'b0;
    t_done = -1;
    ae = 1'bx; to = 1'bx; coe = 1'bx; doe = 1'bx;
    send_byte(8'hF4, 1'b0);
    t = 0;
    while (ps2_clk_oe && t < 1000) begin
      @(negedge clk);
      t++;
    end
    t_rel = cyc;
    t = 0;
    while (!seen && t < START_TO + 500) begin
      @(negedge clk);
      t++;
      if (bus.done) begin
        seen = 1'b1;
        t_done = cyc;
        ae = bus.ack_err;
        to = bus.timeout;
        coe = ps2_clk_oe;
        doe = ps2_data_oe;
      end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL to_done: got %b expected 1", seen); end
    checks++; if (t_done - t_rel != START_TO) begin errors++; $display("[TB] FAIL to_latency: got %0d expected %0d", t_done - t_rel, START_TO); end
    checks++; if (to !== 1'b1) begin errors++; $display("[TB] FAIL to_timeout: got %b expected 1", to); end
    checks++; if (ae !== 1'b0) begin errors++; $display("[TB] FAIL to_ack_err: got %b expected 0", ae); end
    checks++; if (coe !== 1'b0 || doe !== 1'b0) begin errors++; $display("[TB] FAIL to_release: got clk_oe=%b data_oe=%b expected 0 0", coe, doe); end
    @(negedge clk);
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL to_ready: got %b expected 1", bus.tx_ready); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_glitch();
    logic [9:0] rx;
    bit seen;
    logic ae, to;
    send_byte(8'hF4, 1'b0);
    run_device(1'b0, 0, 5, rx);
    checks++; if (rx !== 10'h2F4) begin errors++; $display("[TB] FAIL glitch_frame: got %h expected 2f4", rx); end
    wait_done(seen, ae, to);
    checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL glitch_done: got %b expected 1", seen); end
    checks++; if (ae !== 1'b0) begin errors++; $display("[TB] FAIL glitch_ack_err: got %b expected 0", ae); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic [9:0] rx;
    bit seen;
    logic ae, to;
    int n_done;
    send_byte(8'hF4, 1'b0);
    run_device(1'b0, 4, 0, rx);
    rst = 1'b0;
    #1;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("[TB] FAIL abort_release: got clk_oe=%b data_oe=%b expected 0 0", ps2_clk_oe, ps2_data_oe); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
    @(negedge clk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    checks++; if (n_done != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", n_done); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_ready: got %b expected 1", bus.tx_ready); end
    send_byte(8'hF4, 1'b0);
    run_device(1'b0, 0, 0, rx);
    checks++; if (rx !== 10'h2F4) begin errors++; $display("[TB] FAIL abort_resend_frame: got %h expected 2f4", rx); end
    wait_done(seen, ae, to);
    checks++; if (seen !== 1'b1 || ae !== 1'b0) begin errors++; $display("[TB] FAIL abort_resend_done: got done=%b ack_err=%b expected 1 0", seen, ae); end
    repeat (5) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [9:0] rx;
    bit seen;
    logic ae, to, acc;
    int t;
    send_byte(8'hF4, 1'b1);
    bus.tx_data = 8'hAA;
    run_device(1'b0, 0, 0, rx);
    checks++; if (rx !== 10'h2F4) begin errors++; $display("[TB] FAIL b2b_first_frame: got %h expected 2f4", rx); end
    wait_done(seen, ae, to);
    checks++; if (seen !== 1'b1 || ae !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_done: got done=%b ack_err=%b expected 1 0", seen, ae); end
    t = 0;
    while (bus.busy && t < 20) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    acc = bus.busy;
    bus.tx_valid = 1'b0;
    checks++; if (acc !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept: got busy=%b expected 1", acc); end
    run_device(1'b0, 0, 0, rx);
    checks++; if (rx !== 10'h3AA) begin errors++; $display("[TB] FAIL b2b_second_frame: got %h expected 3aa", rx); end
    wait_done(seen, ae, to);
    checks++; if (seen !== 1'b1 || ae !== 1'b0 || to !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_done: got done=%b ack_err=%b timeout=%b expected 1 0 0", seen, ae, to); end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b0;
    dev_clk      = 1'b1;
    dev_data     = 1'b1;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    test_reset();
    test_send_ack();
    test_nack();
    test_start_timeout();
    test_glitch();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
